// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if
//   Bundles the pipeline-side hazard inputs and the stall/flush controls
//   exchanged between the OTTER datapath and hazard_stall_ctrl.
//   master : datapath side (drives ID/EX hazard info, receives controls)
//   slave  : controller side
//   Signals:
//     id_rs1, id_rs2        source registers of the instruction in ID
//     id_rs1_used/rs2_used  ID instruction actually reads that source
//     ex_rd                 destination register of the instruction in EX
//     ex_mem_read           EX instruction is a load
//     ex_regwrite           EX instruction writes ex_rd
//     ex_branch_taken       EX instruction redirects the PC this cycle
//     dmem_busy             data memory not ready, whole pipe must hold
//     pc_we, if_id_we       PC and IF/ID write enables
//     if_id_flush           load bubble into IF/ID
//     id_ex_flush           load bubble into ID/EX
//     pipe_hold             hold ID/EX, EX/MEM, MEM/WB
//     ld_haz                forward load data from MEM/WB into EX
//     stall_count           saturating count of cycles with pc_we low
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_regwrite;
  logic             ex_branch_taken;
  logic             dmem_busy;
  logic             pc_we;
  logic             if_id_we;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             pipe_hold;
  logic             ld_haz;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd,
           ex_mem_read, ex_regwrite, ex_branch_taken, dmem_busy,
    input  pc_we, if_id_we, if_id_flush, id_ex_flush, pipe_hold,
           ld_haz, stall_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd,
           ex_mem_read, ex_regwrite, ex_branch_taken, dmem_busy,
    output pc_we, if_id_we, if_id_flush, id_ex_flush, pipe_hold,
           ld_haz, stall_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline control for the 5-stage OTTER: load-use stall (ID vs EX),
//   wrong-path squash on taken branches resolved in EX, and a full-pipe
//   freeze while data memory is busy.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    hazard_stall_ctrl_if.slave (hazard inputs, stall/flush outputs)
//   Parameters:
//     FLUSH_CYCLES  cycles if_id_flush stays high after a taken branch (>=1)
//     CNT_W         width of the stall_count performance counter
//
//   state | meaning
//   RUN   | normal issue; taken branch and load-use stall decoded here
//   FLUSH | post-branch IF/ID squash while IMEM refetches; EX holds bubbles
module hazard_stall_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_stall_ctrl_if.slave  bus
);

  localparam int            FW         = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_CYCLES - 1);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic [1:0]       ld_q, ld_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic luh;
  logic pc_we;
  logic if_id_we;
  logic if_id_flush;
  logic id_ex_flush;
  logic pipe_hold;

  assign luh = bus.ex_mem_read && bus.ex_regwrite && (bus.ex_rd != 5'd0) &&
               ((bus.id_rs1_used && (bus.id_rs1 == bus.ex_rd)) ||
                (bus.id_rs2_used && (bus.id_rs2 == bus.ex_rd)));

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    ld_d        = ld_q;
    pc_we       = 1'b1;
    if_id_we    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_hold   = 1'b0;

    if (bus.dmem_busy) begin
      // Everything freezes; branch/luh are re-evaluated once busy drops.
      pipe_hold = 1'b1;
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
    end else begin
      // Bit0 defaults to 0, which also squashes it on a taken branch.
      ld_d = {ld_q[0], 1'b0};
      case (state_q)
        RUN: begin
          if (bus.ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              fcnt_d  = FLUSH_INIT;
            end
          end else if (luh) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
            ld_d[0]     = 1'b1;
          end
        end
        FLUSH: begin
          if_id_flush = 1'b1;
          fcnt_d      = fcnt_q - FW'(1);
          if (fcnt_q == FW'(1)) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      ld_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      ld_q    <= ld_d;
      if (!pc_we && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // Reset forces a safe bubble-everything output pattern without waiting for a clock.
  assign bus.pc_we       = rst_n & pc_we;
  assign bus.if_id_we    = rst_n & if_id_we;
  assign bus.if_id_flush = ~rst_n | if_id_flush;
  assign bus.id_ex_flush = ~rst_n | id_ex_flush;
  assign bus.pipe_hold   = rst_n & pipe_hold;
  assign bus.ld_haz      = ld_q[1];
  assign bus.stall_count = stall_cnt_q;

endmodule
